// File: rtl/player_input_ctrl.sv
// player_input_ctrl: conditions one player's raw buttons into the
// move_left/move_right/jump/move_enable controls consumed by player_move.
// Buttons are synchronised on every clk; everything else advances on SCEN ticks.
module player_input_ctrl #(
  parameter int unsigned DB_TICKS      = 4,
  parameter int unsigned JUMP_BUF      = 6,
  parameter int unsigned RECOVER_TICKS = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic SCEN,
  input  logic btn_left,
  input  logic btn_right,
  input  logic btn_jump,
  input  logic attack_busy,
  input  logic jump_active,
  output logic move_left,
  output logic move_right,
  output logic jump,
  output logic move_enable
);

  localparam int unsigned DBW = $clog2(DB_TICKS + 1);
  localparam int unsigned JBW = $clog2(JUMP_BUF + 1);
  localparam int unsigned RCW = $clog2(RECOVER_TICKS + 1);

  typedef enum logic [1:0] {DIR_NONE, DIR_LEFT, DIR_RIGHT} dir_t;
  typedef enum logic [1:0] {ST_RUN, ST_LOCK, ST_REC} lock_t;

  // Button vectors are packed {jump, right, left}
  logic [2:0]          sync_q1, sync_q2;
  logic [2:0]          deb_q, deb_d;
  logic [2:0][DBW-1:0] db_cnt_q, db_cnt_d;
  logic [2:0]          rise, fall;

  dir_t                dir_q, dir_d;
  logic                pend_q, pend_d;
  logic [JBW-1:0]      jtmr_q, jtmr_d;
  logic                jump_d;

  lock_t               lock_q, lock_d;
  logic [RCW-1:0]      rcnt_q, rcnt_d;

  // Two-flop synchroniser for the raw buttons, clocked every cycle
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q1 <= '0;
      sync_q2 <= '0;
    end else begin
      sync_q1 <= {btn_jump, btn_right, btn_left};
      sync_q2 <= sync_q1;
    end
  end

  // Debounce, direction arbitration and jump buffering (next-tick values)
  always_comb begin
    deb_d    = deb_q;
    db_cnt_d = db_cnt_q;
    for (int unsigned i = 0; i < 3; i++) begin
      if (sync_q2[i] != deb_q[i]) begin
        // Flipping on the DB_TICKS-th differing tick equals "count reaches DB_TICKS, then clear"
        if (db_cnt_q[i] == DBW'(DB_TICKS - 1)) begin
          deb_d[i]    = ~deb_q[i];
          db_cnt_d[i] = '0;
        end else begin
          db_cnt_d[i] = db_cnt_q[i] + 1'b1;
        end
      end else begin
        db_cnt_d[i] = '0;
      end
    end
    rise = deb_d & ~deb_q;
    fall = ~deb_d & deb_q;

    // Release of the owning direction hands over first; a lone new press then overrides
    dir_d = dir_q;
    if (dir_q == DIR_LEFT && fall[0])
      dir_d = deb_d[1] ? DIR_RIGHT : DIR_NONE;
    if (dir_q == DIR_RIGHT && fall[1])
      dir_d = deb_d[0] ? DIR_LEFT : DIR_NONE;
    if (rise[0] && !rise[1])
      dir_d = DIR_LEFT;
    else if (rise[1] && !rise[0])
      dir_d = DIR_RIGHT;

    jump_d = 1'b0;
    pend_d = pend_q;
    jtmr_d = jtmr_q;
    if (rise[2]) begin
      if (!jump_active) begin
        jump_d = 1'b1;
        pend_d = 1'b0;
        jtmr_d = '0;
      end else begin
        pend_d = 1'b1;
        jtmr_d = JBW'(JUMP_BUF);
      end
    end else if (pend_q) begin
      if (!jump_active) begin
        jump_d = 1'b1;
        pend_d = 1'b0;
        jtmr_d = '0;
      end else if (jtmr_q <= JBW'(1)) begin
        pend_d = 1'b0;
        jtmr_d = '0;
      end else begin
        jtmr_d = jtmr_q - 1'b1;
      end
    end
  end

  // Post-attack lockout: next state and recovery count
  always_comb begin
    lock_d = lock_q;
    rcnt_d = rcnt_q;
    case (lock_q)
      ST_RUN: if (attack_busy) lock_d = ST_LOCK;
      ST_LOCK: begin
        if (!attack_busy) begin
          lock_d = ST_REC;
          rcnt_d = RCW'(RECOVER_TICKS);
        end
      end
      ST_REC: begin
        if (attack_busy) begin
          lock_d = ST_LOCK;
        end else begin
          rcnt_d = rcnt_q - 1'b1;
          if (rcnt_q == RCW'(1)) lock_d = ST_RUN;
        end
      end
      default: lock_d = ST_RUN;
    endcase
  end

  // Tick-rate state registers: debounce, direction, jump buffer, lockout FSM
  always_ff @(posedge clk) begin
    if (reset) begin
      deb_q    <= '0;
      db_cnt_q <= '0;
      dir_q    <= DIR_NONE;
      pend_q   <= 1'b0;
      jtmr_q   <= '0;
      lock_q   <= ST_RUN;
      rcnt_q   <= '0;
    end else if (SCEN) begin
      deb_q    <= deb_d;
      db_cnt_q <= db_cnt_d;
      dir_q    <= dir_d;
      pend_q   <= pend_d;
      jtmr_q   <= jtmr_d;
      lock_q   <= lock_d;
      rcnt_q   <= rcnt_d;
    end
  end

  // Registered outputs, updated on ticks and held in between
  always_ff @(posedge clk) begin
    if (reset) begin
      move_left   <= 1'b0;
      move_right  <= 1'b0;
      jump        <= 1'b0;
      move_enable <= 1'b0;
    end else if (SCEN) begin
      move_left   <= (dir_d == DIR_LEFT);
      move_right  <= (dir_d == DIR_RIGHT);
      jump        <= jump_d;
      move_enable <= (lock_d == ST_RUN);
    end
  end

endmodule

// File: tb/tb_player_input_ctrl.sv
// Scoreboard bench for player_input_ctrl: the stimulus pushes the expected
// output word for every clock, the monitor pops and compares after each edge.
module tb_player_input_ctrl;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic SCEN = 1'b0;
  logic btn_left = 1'b0, btn_right = 1'b0, btn_jump = 1'b0;
  logic attack_busy = 1'b0, jump_active = 1'b0;
  logic move_left, move_right, jump, move_enable;

  // Expected word layout: {move_enable, jump, move_right, move_left}
  localparam logic [3:0] ML = 4'b0001;
  localparam logic [3:0] MR = 4'b0010;
  localparam logic [3:0] JP = 4'b0100;
  localparam logic [3:0] ME = 4'b1000;

  typedef struct {
    logic [3:0] exp;
    string      name;
  } exp_t;

  exp_t       sb[$];
  int         checks = 0;
  int         passes = 0;
  bit         started = 1'b0;
  logic [3:0] hold_exp = 4'b0000;
  string      hold_name = "reset";

  player_input_ctrl #(
    .DB_TICKS      (4),
    .JUMP_BUF      (6),
    .RECOVER_TICKS (8)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .SCEN        (SCEN),
    .btn_left    (btn_left),
    .btn_right   (btn_right),
    .btn_jump    (btn_jump),
    .attack_busy (attack_busy),
    .jump_active (jump_active),
    .move_left   (move_left),
    .move_right  (move_right),
    .jump        (jump),
    .move_enable (move_enable)
  );

  always #5 clk = ~clk;

  task automatic push(input logic [3:0] e, input string nm);
    exp_t x;
    x.exp  = e;
    x.name = nm;
    sb.push_back(x);
  endtask

  // Three idle clocks (outputs must hold) then one SCEN clock; called at a negedge
  task automatic tick(input logic [3:0] e, input string nm);
    for (int i = 0; i < 3; i++) begin
      push(hold_exp, {hold_name, "_hold"});
      @(negedge clk);
    end
    SCEN = 1'b1;
    push(e, nm);
    @(negedge clk);
    SCEN = 1'b0;
    hold_exp  = e;
    hold_name = nm;
  endtask

  task automatic ticks(input int n, input logic [3:0] e, input string nm);
    for (int i = 0; i < n; i++) tick(e, nm);
  endtask

  task automatic rst_cycle(input string nm);
    reset = 1'b1;
    push(4'b0000, nm);
    @(negedge clk);
    reset = 1'b0;
    hold_exp  = 4'b0000;
    hold_name = nm;
  endtask

  // Monitor: one expected word per clock while checking is active
  initial begin
    exp_t       e;
    logic [3:0] act;
    forever begin
      @(posedge clk);
      if (started) begin
        #1;
        checks++;
        act = {move_enable, jump, move_right, move_left};
        if (sb.size() == 0) begin
          $display("FAIL scoreboard_underflow: got output %b with no expected entry queued", act);
        end else begin
          e = sb.pop_front();
          if (((act ^ e.exp) === 4'b0000)) passes++;
          else $display("FAIL %s: got {en,jump,r,l}=%b expected %b at %0t", e.name, act, e.exp, $time);
        end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

  initial begin
    repeat (3) @(negedge clk);
    started = 1'b1;
    rst_cycle("reset_state");

    // Right held: flips on the 4th tick once synchronised
    btn_right = 1'b1;
    ticks(3, ME, "r_debouncing");
    tick(ME | MR, "r_press_tick4");
    tick(ME | MR, "r_held");
    btn_right = 1'b0;
    ticks(3, ME | MR, "r_release_deb");
    tick(ME, "r_released");

    // Left glitch of 3 ticks must not register, and must not pre-load the counter
    btn_left = 1'b1;
    ticks(3, ME, "l_glitch");
    btn_left = 1'b0;
    ticks(2, ME, "l_glitch_gone");

    // Left held, right pressed later wins, release right hands back to left
    btn_left = 1'b1;
    ticks(3, ME, "l_deb");
    tick(ME | ML, "l_press");
    ticks(9, ME | ML, "l_held");
    btn_right = 1'b1;
    ticks(3, ME | ML, "r_over_deb");
    tick(ME | MR, "r_over_l");
    ticks(2, ME | MR, "r_over_held");
    btn_right = 1'b0;
    ticks(3, ME | MR, "r_rel_deb");
    tick(ME | ML, "handoff_l");
    btn_left = 1'b0;
    ticks(3, ME | ML, "l_rel_deb");
    tick(ME, "l_released");

    // Both directions rising on the same tick leave last_dir unchanged (NONE)
    btn_left = 1'b1;
    btn_right = 1'b1;
    ticks(4, ME, "both_same_tick");
    btn_left = 1'b0;
    btn_right = 1'b0;
    ticks(4, ME, "both_released");

    // Grounded jump: one pulse, no re-fire while held
    btn_jump = 1'b1;
    ticks(3, ME, "j_deb");
    tick(ME | JP, "j_direct");
    tick(ME, "j_one_period");
    tick(ME, "j_held");
    btn_jump = 1'b0;
    ticks(4, ME, "j_release");

    // Airborne press, landing 3 ticks after the debounced rise fires once
    jump_active = 1'b1;
    btn_jump = 1'b1;
    ticks(4, ME, "jb_pending");
    ticks(2, ME, "jb_airborne");
    jump_active = 1'b0;
    tick(ME | JP, "jb_fire_r3");
    ticks(2, ME, "jb_single");
    jump_active = 1'b1;
    btn_jump = 1'b0;
    ticks(4, ME, "jb_release");

    // Airborne press, landing 7 ticks after the rise: buffer already expired
    btn_jump = 1'b1;
    ticks(4, ME, "jx_pending");
    ticks(6, ME, "jx_airborne");
    jump_active = 1'b0;
    ticks(3, ME, "jx_expired");
    btn_jump = 1'b0;
    ticks(4, ME, "jx_release");

    // Attack lockout: 5 busy ticks, then exactly 8 ticks of recovery
    attack_busy = 1'b1;
    ticks(5, 4'b0000, "lock_busy");
    attack_busy = 1'b0;
    ticks(8, 4'b0000, "rec_count");
    tick(ME, "rec_done");
    tick(ME, "run");

    // Busy again while recovery count is 3 goes back to LOCK and restarts recovery
    attack_busy = 1'b1;
    ticks(2, 4'b0000, "lock2");
    attack_busy = 1'b0;
    ticks(6, 4'b0000, "rec2");
    attack_busy = 1'b1;
    tick(4'b0000, "rec_rebusy");
    attack_busy = 1'b0;
    ticks(8, 4'b0000, "rec3");
    tick(ME, "rec3_done");

    // Reset during a jump pulse while in recovery
    attack_busy = 1'b1;
    tick(4'b0000, "t6_lock");
    attack_busy = 1'b0;
    tick(4'b0000, "t6_rec");
    btn_jump = 1'b1;
    btn_right = 1'b1;
    ticks(3, 4'b0000, "t6_deb");
    tick(JP | MR, "t6_pulse");
    btn_jump = 1'b0;
    btn_right = 1'b0;
    rst_cycle("mid_reset");
    tick(ME, "post_reset_tick1");
    ticks(4, ME, "post_reset");

    started = 1'b0;
    checks++;
    if (sb.size() == 0) passes++;
    else $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
